lfsr_period_meter: RTL and testbench
====================================

# lfsr_period_meter

Downstream consumer of the 4-bit LFSR stage. Samples the LFSR state stream, measures its cycle period (samples until the first captured state recurs) and shows the result on the board's 7-segment display, alternating the two hex digits. Used on silicon to confirm that each `mod` tap setting gives a maximal (15) or degenerate sequence without a logic analyser.

## Interface
- `DISP_DIV_W`, default 20: width of the digit-alternation divider; the digit toggles every 2^DISP_DIV_W clocks.
- `TIMEOUT`, default 31: the largest sample count allowed before the measurement fails; must be at most 31.
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `ena` in 1: block enable; when low, state and counters hold.
- `lfsr_in` in 4: LFSR state from the upstream stage.
- `lfsr_vld` in 1: `lfsr_in` is a new sample this cycle.
- `start` in 1: level-sampled request to begin a measurement.
- `seg_out` out 7: segments a..g on bits [0]..[6], active-high.
- `dp` out 1: digit indicator; 0 = low digit shown, 1 = high digit shown.
- `period` out 5: last measured period; 0 when no valid result is held.
- `done` out 1: a valid result is held.
- `stuck` out 1: the last result was period 1 (LFSR locked).
- `err` out 1: the last measurement timed out.

## Operation
- Reset values: state IDLE; `period`=0; `done`, `stuck`, `err`, `dp`=0; `seg_out`=7'h40 (dash).
- States:
  - **IDLE**: shows a dash. `start` moves to ARM.
  - **ARM**: the first cycle with `lfsr_vld` captures `ref`=`lfsr_in`, sets `cnt`=0 and moves to MEASURE.
  - **MEASURE**: each `lfsr_vld` cycle increments `cnt`.
    - If `lfsr_in`==`ref`, then `period`=`cnt`+1 and the block moves to REPORT.
    - Otherwise, if `cnt`+1==`TIMEOUT`, the block moves to FAIL.
  - **REPORT**: `done`=1, and `stuck`=1 when `period`==1. Display alternates between hex(`period[3:0]`) with `dp`=0 and hex({3'b0,`period[4]`}) with `dp`=1.
  - **FAIL**: `err`=1, `period`=0, display shows "E" (7'h79), `dp`=0.
- `start` in any state, including MEASURE, restarts the measurement:
  - next state is ARM;
  - `done`, `stuck`, `err` and `period` clear on that edge.
- Cycles without `lfsr_vld` never advance `cnt`; the period is counted in samples, not clocks.
- ARM, MEASURE and IDLE show a dash with `dp`=0.
- Display divider:
  - runs only in REPORT;
  - is cleared on entry to REPORT, so the low digit is shown first.
- When `ena`=0, every register holds, including the divider. Outputs keep their values.
- Async reset in any state returns to the reset values immediately.

## Timing
- `start` high at edge N gives ARM at N+1. A `lfsr_vld` sample at ARM is captured at edge N+1.
- A matching sample at edge M sets `period`/`done` and the REPORT display, all visible after edge M. That is a 1-cycle registered latency.
- Every output is registered; there are no combinational paths from input to output.
- If `start` and a matching sample occur together in MEASURE, `start` wins: the block goes to ARM and records no result.
- The first digit toggle comes 2^DISP_DIV_W cycles after REPORT entry.

## Configuration
- `LFSR_METER_AUTORESTART_EN`:
  - Defined: when REPORT or FAIL has held for 4 digit toggles (2 full display rounds), the block re-enters ARM on its own, so tap changes are tracked continuously.
  - Undefined: REPORT and FAIL hold until `start` or reset.

## Structure
- `lfsr_meter_pkg` holds:
  - the state enum (IDLE, ARM, MEASURE, REPORT, FAIL);
  - segment constants SEG_DASH=7'h40 and SEG_E=7'h79;
  - the default TIMEOUT.
- Sub-module `hex_to_seg7`: a purely combinational mapping from a 4-bit value to 7 segments, in a..g order, active-high. Its output is registered in the parent.

## Test plan
- **Maximal sequence:** a 15-value maximal LFSR sequence, one sample per cycle, then `start` → `period`=15 and `done`=1. With DISP_DIV_W=3, `seg_out` is 7'h71 ("F") with `dp`=0 for 8 cycles, then 7'h3F ("0") with `dp`=1.
- **Locked LFSR:** constant `lfsr_in`=0 → after 2 samples `period`=1, `stuck`=1, display shows "1" (7'h06).
- **Valid gaps:** a 3-value repeating sequence with `lfsr_vld` low on alternate cycles → `period`=3. The result arrives 6 clocks after ARM capture.
- **Timeout:** `ref`=5, then 31 samples that are never 5 → FAIL, `err`=1, `period`=0, display shows 7'h79.
- **Restart and reset:**
  - `start` pulsed mid-MEASURE after 7 samples → back to ARM, `cnt` cleared, the next measurement is correct.
  - `rst_n` pulled low mid-REPORT → all outputs return to their reset values with no clock edge.
- **Auto-restart:** with the macro defined and DISP_DIV_W=2, REPORT returns to ARM 16 cycles after entry. With the macro undefined, REPORT is still held after 100 cycles.

Source files
------------

// File: rtl/lfsr_meter_pkg.sv
// lfsr_meter_pkg: shared state encoding, segment constants and the default
// sample limit for the LFSR period meter.
package lfsr_meter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_MEASURE,
        ST_REPORT,
        ST_FAIL
    } meter_state_e;

    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_E    = 7'h79;

    localparam int TIMEOUT_DEFAULT = 31;

endpackage

// File: rtl/hex_to_seg7.sv
// hex_to_seg7: combinational hex digit to 7-segment decoder.
// Segments a..g are on bits [0]..[6], active-high.
module hex_to_seg7 (
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    // Table lookup; every input value is covered so no latch can form.
    always_comb begin
        seg_o = 7'h00;
        case (hex_i)
            4'h0: seg_o = 7'h3F;
            4'h1: seg_o = 7'h06;
            4'h2: seg_o = 7'h5B;
            4'h3: seg_o = 7'h4F;
            4'h4: seg_o = 7'h66;
            4'h5: seg_o = 7'h6D;
            4'h6: seg_o = 7'h7D;
            4'h7: seg_o = 7'h07;
            4'h8: seg_o = 7'h7F;
            4'h9: seg_o = 7'h6F;
            4'hA: seg_o = 7'h77;
            4'hB: seg_o = 7'h7C;
            4'hC: seg_o = 7'h39;
            4'hD: seg_o = 7'h5E;
            4'hE: seg_o = 7'h79;
            4'hF: seg_o = 7'h71;
            default: seg_o = 7'h00;
        endcase
    end

endmodule

// File: rtl/lfsr_period_meter.sv
// lfsr_period_meter: captures one LFSR sample, counts samples until that value
// recurs and shows the period on a 7-segment digit, alternating low/high hex.
// Optional build macro: LFSR_METER_AUTORESTART_EN re-arms the measurement on
// its own after a result (or timeout) has been shown for 4 digit toggles.
//
// Input handshake: lfsr_vld qualifies lfsr_in for exactly the cycle it is high;
// there is no backpressure, every qualified sample is consumed in that cycle.
// state_dbg mirrors the FSM state register for observation.
module lfsr_period_meter #(
    parameter int DISP_DIV_W = 20,
    parameter int TIMEOUT    = lfsr_meter_pkg::TIMEOUT_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ena,
    input  logic [3:0]                   lfsr_in,
    input  logic                         lfsr_vld,
    input  logic                         start,
    output logic [6:0]                   seg_out,
    output logic                         dp,
    output logic [4:0]                   period,
    output logic                         done,
    output logic                         stuck,
    output logic                         err,
    output lfsr_meter_pkg::meter_state_e state_dbg
);

    import lfsr_meter_pkg::*;

    localparam logic [4:0]            TIMEOUT_CNT = 5'(TIMEOUT);
    localparam logic [DISP_DIV_W-1:0] DIV_ONE     = DISP_DIV_W'(1);
    localparam logic [DISP_DIV_W-1:0] DIV_MAX     = '1;

    meter_state_e          state_q, state_d;
    logic [3:0]            ref_q, ref_d;
    logic [4:0]            cnt_q, cnt_d;
    logic [4:0]            period_q, period_d;
    logic                  done_q, done_d;
    logic                  stuck_q, stuck_d;
    logic                  err_q, err_d;
    logic                  dp_q, dp_d;
    logic [6:0]            seg_q, seg_d;
    logic [DISP_DIV_W-1:0] div_q, div_d;
`ifdef LFSR_METER_AUTORESTART_EN
    logic [1:0]            tog_q, tog_d;
`endif

    logic [4:0] cnt_inc;
    logic       div_wrap;
    logic       auto_rst;
    logic [3:0] digit;
    logic [6:0] hex_seg;

    assign cnt_inc  = cnt_q + 5'd1;
    assign div_wrap = (div_q == DIV_MAX);

    // Next-state and result logic; a restart request overrides everything.
    always_comb begin
        state_d  = state_q;
        ref_d    = ref_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        done_d   = done_q;
        stuck_d  = stuck_q;
        err_d    = err_q;
        dp_d     = dp_q;
        div_d    = div_q;
        auto_rst = 1'b0;
`ifdef LFSR_METER_AUTORESTART_EN
        tog_d    = tog_q;
`endif
        case (state_q)
            ST_IDLE: ;
            ST_ARM: begin
                if (lfsr_vld) begin
                    ref_d   = lfsr_in;
                    cnt_d   = 5'd0;
                    state_d = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                if (lfsr_vld) begin
                    cnt_d = cnt_inc;
                    if (lfsr_in == ref_q) begin
                        period_d = cnt_inc;
                        done_d   = 1'b1;
                        stuck_d  = (cnt_inc == 5'd1);
                        dp_d     = 1'b0;
                        div_d    = '0;
                        state_d  = ST_REPORT;
`ifdef LFSR_METER_AUTORESTART_EN
                        tog_d    = 2'd0;
`endif
                    end else if (cnt_inc == TIMEOUT_CNT) begin
                        period_d = 5'd0;
                        err_d    = 1'b1;
                        dp_d     = 1'b0;
                        div_d    = '0;
                        state_d  = ST_FAIL;
`ifdef LFSR_METER_AUTORESTART_EN
                        tog_d    = 2'd0;
`endif
                    end
                end
            end
            ST_REPORT: begin
                div_d = div_q + DIV_ONE;
                if (div_wrap) begin
                    dp_d = ~dp_q;
`ifdef LFSR_METER_AUTORESTART_EN
                    tog_d    = tog_q + 2'd1;
                    auto_rst = (tog_q == 2'd3);
`endif
                end
            end
            ST_FAIL: begin
`ifdef LFSR_METER_AUTORESTART_EN
                // The divider only paces the re-arm here; the E digit stays put.
                div_d = div_q + DIV_ONE;
                if (div_wrap) begin
                    tog_d    = tog_q + 2'd1;
                    auto_rst = (tog_q == 2'd3);
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase

        if (start || auto_rst) begin
            state_d  = ST_ARM;
            cnt_d    = 5'd0;
            period_d = 5'd0;
            done_d   = 1'b0;
            stuck_d  = 1'b0;
            err_d    = 1'b0;
            dp_d     = 1'b0;
            div_d    = '0;
`ifdef LFSR_METER_AUTORESTART_EN
            tog_d    = 2'd0;
`endif
        end
    end

    // Digit to display next: low nibble of the period, or its top bit.
    assign digit = dp_d ? {3'b000, period_d[4]} : period_d[3:0];

    hex_to_seg7 u_hex (
        .hex_i (digit),
        .seg_o (hex_seg)
    );

    // Segment pattern follows the next state so the display updates with it.
    always_comb begin
        seg_d = SEG_DASH;
        case (state_d)
            ST_REPORT: seg_d = hex_seg;
            ST_FAIL:   seg_d = SEG_E;
            default:   seg_d = SEG_DASH;
        endcase
    end

    // State and output registers; everything holds while ena is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            ref_q    <= 4'd0;
            cnt_q    <= 5'd0;
            period_q <= 5'd0;
            done_q   <= 1'b0;
            stuck_q  <= 1'b0;
            err_q    <= 1'b0;
            dp_q     <= 1'b0;
            seg_q    <= SEG_DASH;
            div_q    <= '0;
`ifdef LFSR_METER_AUTORESTART_EN
            tog_q    <= 2'd0;
`endif
        end else if (ena) begin
            state_q  <= state_d;
            ref_q    <= ref_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            done_q   <= done_d;
            stuck_q  <= stuck_d;
            err_q    <= err_d;
            dp_q     <= dp_d;
            seg_q    <= seg_d;
            div_q    <= div_d;
`ifdef LFSR_METER_AUTORESTART_EN
            tog_q    <= tog_d;
`endif
        end
    end

    assign seg_out   = seg_q;
    assign dp        = dp_q;
    assign period    = period_q;
    assign done      = done_q;
    assign stuck     = stuck_q;
    assign err       = err_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_lfsr_period_meter.sv
// tb_lfsr_period_meter: scoreboard bench for lfsr_period_meter.
// Expected results come from a recurrence model over the driven sample list.
module tb_lfsr_period_meter;

    import lfsr_meter_pkg::*;

    localparam int DIV_W   = 3;
    localparam int TMO     = 31;
    localparam logic [6:0] SEG_E_EXP    = 7'h79;
    localparam logic [6:0] SEG_DASH_EXP = 7'h40;

    // ---------------- clock / reset / DUT ----------------
    logic clk = 1'b0;
    logic rst_n, ena, lfsr_vld, start;
    logic [3:0] lfsr_in;
    logic [6:0] seg_out;
    logic dp, done, stuck, err;
    logic [4:0] period;
    meter_state_e state_dbg;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    lfsr_period_meter #(.DISP_DIV_W(DIV_W), .TIMEOUT(TMO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .lfsr_in   (lfsr_in),
        .lfsr_vld  (lfsr_vld),
        .start     (start),
        .seg_out   (seg_out),
        .dp        (dp),
        .period    (period),
        .done      (done),
        .stuck     (stuck),
        .err       (err),
        .state_dbg (state_dbg)
    );

    // ---------------- scoreboard state ----------------
    logic [13:0] exp_q[$];          // {period, stuck, err, seg}
    int n_checks = 0;
    int n_fail   = 0;
    int cap_cyc  = 0;
    int res_cyc  = 0;

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic [3:0] s [32];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference: the period is the index of the first later sample equal to
    // the captured one; none within TMO samples means a timeout.
    function automatic logic [13:0] model(input logic [3:0] sq [32], output int n);
        for (int i = 1; i <= TMO; i++) begin
            if (sq[i] == sq[0]) begin
                n = i;
                return {5'(i), (i == 1), 1'b0, seg_tab[i % 16]};
            end
        end
        n = TMO;
        return {5'd0, 1'b0, 1'b1, SEG_E_EXP};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send_start();
        @(posedge clk); #1;
        start = 1'b1; lfsr_vld = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // gmode: 0 back-to-back, 1 one idle cycle first, 2 random idle/gated
    // cycles, 3 two ena-low cycles presenting the reference value.
    task automatic send_sample(input logic [3:0] v, input int gmode, input logic [3:0] refv);
        int ng;
        ng = (gmode == 0) ? 0 : (gmode == 1) ? 1 : (gmode == 2) ? $urandom_range(0, 2) : 2;
        for (int g = 0; g < ng; g++) begin
            if (gmode == 1 || (gmode == 2 && $urandom_range(0, 1) == 0)) begin
                ena = 1'b1; lfsr_vld = 1'b0; lfsr_in = 4'($urandom_range(0, 15));
            end else begin
                ena = 1'b0; lfsr_vld = 1'b1; lfsr_in = refv;
            end
            @(posedge clk); #1;
        end
        ena = 1'b1; lfsr_vld = 1'b1; lfsr_in = v;
        @(posedge clk); #1;
        lfsr_vld = 1'b0;
    endtask

    task automatic wait_result();
        for (int k = 0; k < 6 && exp_q.size() != 0; k++) @(negedge clk);
        check("result_seen", exp_q.size(), 0);
    endtask

    task automatic run_meas(input int gmode, input bit do_start, input bit wait_res);
        int n;
        exp_q.push_back(model(s, n));
        if (do_start) send_start();
        send_sample(s[0], 0, s[0]);
        cap_cyc = cyc;
        for (int i = 1; i <= n; i++) send_sample(s[i], gmode, s[0]);
        if (wait_res) wait_result();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_seg"},    seg_out, SEG_DASH_EXP);
        check({tag, "_dp"},     dp, 0);
        check({tag, "_period"}, period, 0);
        check({tag, "_done"},   done, 0);
        check({tag, "_stuck"},  stuck, 0);
        check({tag, "_err"},    err, 0);
        check({tag, "_state"},  state_dbg, ST_IDLE);
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        logic prev;
        logic [13:0] e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                prev = 1'b0;
            end else begin
                if ((done | err) && !prev) begin
                    res_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        check("unexpected_result", {period, done, err}, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("result", {period, stuck, err, seg_out}, e);
                        check("result_dp", dp, 0);
                        check("result_done", done, !e[7]);
                    end
                end
                prev = done | err;
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0] v;
        int amax;
        rst_n = 1'b1; ena = 1'b1; start = 1'b0; lfsr_vld = 1'b0; lfsr_in = 4'd0;
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Maximal x^4+x^3+1 sequence: period 15, F then 0 on the display.
        v = 4'd1;
        for (int i = 0; i < 32; i++) begin
            s[i] = v;
            v = {v[2:0], v[3] ^ v[2]};
        end
        run_meas(0, 1'b1, 1'b0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("max_low_seg", seg_out, 7'h71);
            check("max_low_dp", dp, 0);
        end
        @(negedge clk);
        check("max_high_seg", seg_out, 7'h3F);
        check("max_high_dp", dp, 1);
        check("max_period", period, 15);
        check("max_seen", exp_q.size(), 0);
`ifdef LFSR_METER_AUTORESTART_EN
        for (int k = 0; k < 60 && state_dbg != ST_ARM; k++) @(negedge clk);
        check("autorestart_cycles", res_cyc + 4 * (1 << DIV_W) <= cyc, 1);
        check("autorestart_state", state_dbg, ST_ARM);
`else
        repeat (100) @(negedge clk);
        check("hold_state", state_dbg, ST_REPORT);
        check("hold_done", done, 1);
`endif

        // Async reset while a result is shown, checked before any clock edge.
        send_start();
        for (int i = 0; i < 32; i++) s[i] = 4'(i % 4);
        run_meas(0, 1'b0, 1'b1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1 check_reset_outputs("async_rst");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Locked LFSR: constant zero gives period 1.
        for (int i = 0; i < 32; i++) s[i] = 4'd0;
        run_meas(0, 1'b1, 1'b1);
        check("locked_seg", seg_out, 7'h06);
        check("locked_stuck", stuck, 1);

        // Valid gaps: period 3 with an idle cycle before each sample.
        for (int i = 0; i < 32; i++) s[i] = (i % 3 == 0) ? 4'd3 : (i % 3 == 1) ? 4'd9 : 4'd12;
        run_meas(1, 1'b1, 1'b1);
        check("gap_period", period, 3);
        check("gap_latency", res_cyc - cap_cyc, 6);

        // Timeout: reference 5, never seen again.
        s[0] = 4'd5;
        for (int i = 1; i < 32; i++) begin
            do v = 4'($urandom_range(0, 15)); while (v == 4'd5);
            s[i] = v;
        end
        run_meas(0, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        check("timeout_state", state_dbg, ST_FAIL);
        check("timeout_seg", seg_out, SEG_E_EXP);
        check("timeout_period", period, 0);

        // Restart mid-measure after 7 non-matching samples.
        send_start();
        send_sample(4'd4, 0, 4'd4);
        for (int i = 0; i < 7; i++) begin
            do v = 4'($urandom_range(0, 15)); while (v == 4'd4);
            send_sample(v, 0, 4'd4);
        end
        send_start();
        check("restart_state", state_dbg, ST_ARM);
        check("restart_done", done, 0);
        for (int i = 0; i < 32; i++) s[i] = 4'(i % 5 + 2);
        run_meas(0, 1'b0, 1'b1);

        // Start coinciding with a matching sample: start wins, no result.
        send_start();
        send_sample(4'd7, 0, 4'd7);
        send_sample(4'd2, 0, 4'd7);
        start = 1'b1; lfsr_vld = 1'b1; lfsr_in = 4'd7;
        @(posedge clk); #1;
        start = 1'b0; lfsr_vld = 1'b0;
        @(negedge clk);
        check("startwins_state", state_dbg, ST_ARM);
        check("startwins_done", done, 0);
        check("startwins_period", period, 0);

        // ena low while a matching sample is presented must not count it.
        for (int i = 0; i < 32; i++) s[i] = (i % 2 == 0) ? 4'd6 : 4'd1;
        run_meas(3, 1'b0, 1'b1);

        // Random streams from alphabets of varying size, random gaps.
        for (int t = 0; t < 24; t++) begin
            amax = (t % 4 == 0) ? 1 : (t % 4 == 1) ? 3 : (t % 4 == 2) ? 7 : 15;
            for (int i = 0; i < 32; i++) s[i] = 4'($urandom_range(0, amax));
            run_meas($urandom_range(0, 2), 1'b1, 1'b1);
        end

        repeat (4) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
